// File: rtl/cmp_wide_sequencer.sv
// Serial wide-operand magnitude compare: walks the bytes MSB-first through one shared
// 8-bit comparator and stops at the first unequal byte pair.
module cmp_wide_sequencer #(
    parameter int unsigned NBYTES     = 4,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned IDX_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    output logic                  busy,
    output logic                  done,
    output logic                  res_gt,
    output logic                  res_eq,
    output logic                  res_lt,
    output logic                  err,
    output logic [7:0]            cmp_a,
    output logic [7:0]            cmp_b,
    input  logic                  cmp_gt,
    input  logic                  cmp_eq,
    input  logic                  cmp_lt
);

    localparam int unsigned OP_W  = 8 * NBYTES;
    localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic {IDLE, WAIT} state_e;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_dec;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              res_gt_q, res_gt_d, res_eq_q, res_eq_d, res_lt_q, res_lt_d;
    logic              err_q, err_d;
    logic [7:0]        cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
    logic [2:0]        flags;
    logic              fin;

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        res_gt_d = res_gt_q;
        res_eq_d = res_eq_q;
        res_lt_d = res_lt_q;
        err_d    = err_q;
        cmp_a_d  = cmp_a_q;
        cmp_b_d  = cmp_b_q;
        fin      = 1'b0;
        flags    = {cmp_gt, cmp_eq, cmp_lt};
        idx_dec  = idx_q - IDX_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_a_d  = op_a;
                    sh_b_d  = op_b;
                    idx_d   = IDX_W'(NBYTES - 1);
                    cmp_a_d = op_a[OP_W-1 -: 8];
                    cmp_b_d = op_b[OP_W-1 -: 8];
                    cnt_d   = CNT_W'(SETTLE_CYC - 1);
                    busy_d  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    case (flags)
                        3'b010: begin
                            if (idx_q != '0) begin
                                idx_d   = idx_dec;
                                cmp_a_d = 8'(sh_a_q >> {idx_dec, 3'b000});
                                cmp_b_d = 8'(sh_b_q >> {idx_dec, 3'b000});
                                cnt_d   = CNT_W'(SETTLE_CYC - 1);
                            end else begin
                                {res_gt_d, res_eq_d, res_lt_d, err_d} = 4'b0100;
                                fin = 1'b1;
                            end
                        end
                        3'b100: begin
                            {res_gt_d, res_eq_d, res_lt_d, err_d} = 4'b1000;
                            fin = 1'b1;
                        end
                        3'b001: begin
                            {res_gt_d, res_eq_d, res_lt_d, err_d} = 4'b0010;
                            fin = 1'b1;
                        end
                        default: begin
                            // Flags not one-hot: the comparator cannot be trusted
                            {res_gt_d, res_eq_d, res_lt_d, err_d} = 4'b0001;
                            fin = 1'b1;
                        end
                    endcase
                end
                if (fin) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_gt_q <= 1'b0;
            res_eq_q <= 1'b0;
            res_lt_q <= 1'b0;
            err_q    <= 1'b0;
            cmp_a_q  <= '0;
            cmp_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            res_gt_q <= res_gt_d;
            res_eq_q <= res_eq_d;
            res_lt_q <= res_lt_d;
            err_q    <= err_d;
            cmp_a_q  <= cmp_a_d;
            cmp_b_q  <= cmp_b_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign res_gt = res_gt_q;
    assign res_eq = res_eq_q;
    assign res_lt = res_lt_q;
    assign err    = err_q;
    assign cmp_a  = cmp_a_q;
    assign cmp_b  = cmp_b_q;

endmodule
